multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 The ports SHALL be as follows, clock and reset first:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- opcode  in  7  decoded opcode from the instruction register.
- mem_ready  in  1  memory completion strobe, one cycle.
- branch_taken  in  1  ALU compare result; valid in EXEC.
- halt_req  in  1  level request to stop at the next instruction boundary.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable, store only.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC update.
- pc_sel  out  1  0 = PC+4, 1 = branch target.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- alu_op  out  2  00 = add, 01 = compare/sub, 10 = funct-decoded.
- reg_we  out  1  register file write.
- wb_sel  out  1  0 = ALU, 1 = memory data.
- state  out  3  current state encoding.
- illegal  out  1  sticky illegal-opcode flag.
- instr_count  out  32  retired-instruction counter.

Function
REQ-003 The opcode classes SHALL be: R = 7'b0000000, LOAD = 7'b0100011, STORE = 7'b0101011, BRANCH = 7'b0000100. Every other opcode SHALL be illegal.
REQ-004 The state encoding SHALL be: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5. Encodings 6 and 7 SHALL go to HALT on the next edge.
REQ-005 All outputs SHALL be Moore-decoded from state, except these, which are combinational on inputs: ir_we, pc_we, pc_sel, the FETCH/MEM exits and instr_count increment.
REQ-006 Any output not asserted by the current state SHALL be 0.
REQ-007 FETCH: mem_req=1, mem_addr_sel=0.
- Hold FETCH until mem_ready=1.
- In that cycle: ir_we=1, next state DECODE.
REQ-008 DECODE SHALL last exactly 1 cycle.
- Legal class: go to EXEC.
- Illegal: go to HALT and set illegal=1.
REQ-009 EXEC for R SHALL drive alu_src_b=0, alu_op=10, then go to WB.
REQ-010 EXEC for LOAD/STORE SHALL drive alu_src_b=1, alu_op=00, then go to MEM.
REQ-011 EXEC for BRANCH SHALL drive alu_src_b=0, alu_op=01, pc_we=1, pc_sel=branch_taken, and retire.
REQ-012 MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE only.
- Hold MEM until mem_ready=1.
- STORE then retires with pc_we=1, pc_sel=0.
- LOAD then goes to WB.
REQ-013 WB SHALL drive reg_we=1, wb_sel=1 for LOAD (0 for R), pc_we=1, pc_sel=0, and retire.
REQ-014 Once raised, mem_req SHALL stay high with stable mem_addr_sel/mem_we until mem_ready is sampled high. mem_ready while mem_req=0 SHALL be ignored.
REQ-015 Retire cycle: instr_count increments by 1 (wraps 32'hFFFFFFFF -> 0). Next state is HALT if halt_req=1, else FETCH.
REQ-016 halt_req SHALL have no effect outside a retire cycle. In-flight memory transactions are never aborted.
REQ-017 HALT SHALL drive all strobes to 0 and hold until rst.
REQ-018 Per-class latency with zero-wait memory (mem_ready in the first request cycle) SHALL be:
- R: 4 cycles.
- LOAD: 5 cycles.
- STORE: 4 cycles.
- BRANCH: 3 cycles.
- Each wait cycle adds 1.
REQ-019 The opcode input SHALL be sampled only in DECODE and EXEC, and the IR SHALL hold it stable.

Reset
REQ-020 rst=1 SHALL immediately, without a clock, force: state=FETCH, illegal=0, instr_count=0, and all strobes to their FETCH Moore values.
REQ-021 Reset asserted mid-MEM or mid-FETCH SHALL drop the transaction. mem_ready arriving after reset release SHALL be treated as a fresh FETCH response.
REQ-022 The first mem_req SHALL assert in the first cycle of FETCH after rst deasserts.

Verification
REQ-023 R instruction, opcode 0, mem_ready on first FETCH cycle -> states 0,1,2,4,0. reg_we=1 and wb_sel=0 in WB; instr_count 0->1.
REQ-024 LOAD with 3 FETCH wait cycles and 2 MEM wait cycles -> retire on cycle 10. In WB, reg_we=1, wb_sel=1, mem_we never 1.
REQ-025 STORE then BRANCH with branch_taken=1 -> STORE: mem_we=1 only in MEM, no reg_we. BRANCH: pc_we=1, pc_sel=1 in EXEC. instr_count=2.
REQ-026 opcode 7'b1111111 -> HALT after DECODE, illegal=1, instr_count unchanged. Strobes stay 0 for 20 cycles; rst clears illegal.
REQ-027 halt_req=1 during MEM wait, then held -> the store completes and retires, state=5, no further mem_req.
REQ-028 rst pulsed mid-FETCH with mem_req=1 -> immediately state=0, instr_count=0. After release, mem_req=1 and a late mem_ready is accepted as the fetch.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle processor control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory handshake, sticky illegal-opcode flag and retired-instruction counter.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  input  logic        branch_taken,
  input  logic        halt_req,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic        wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ClsR,
    ClsLoad,
    ClsStore,
    ClsBranch
  } cls_e;

  localparam logic [6:0] OpR      = 7'b0000000;
  localparam logic [6:0] OpLoad   = 7'b0100011;
  localparam logic [6:0] OpStore  = 7'b0101011;
  localparam logic [6:0] OpBranch = 7'b0000100;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  logic        illegal_q, illegal_d;
  logic [31:0] count_q, count_d;

  cls_e        dec_cls;
  logic        dec_legal;
  logic        retire;

  always_comb begin
    dec_cls   = ClsR;
    dec_legal = 1'b1;
    unique case (opcode)
      OpR:      dec_cls = ClsR;
      OpLoad:   dec_cls = ClsLoad;
      OpStore:  dec_cls = ClsStore;
      OpBranch: dec_cls = ClsBranch;
      default:  dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      cls_q     <= ClsR;
      illegal_q <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Next state plus the input-dependent strobes (ir_we, pc_we, pc_sel).
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    case (state_q)
      StFetch: begin
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        cls_d = dec_cls;
        if (dec_legal) begin
          state_d = StExec;
        end else begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end
      end
      StExec: begin
        unique case (cls_q)
          ClsR:              state_d = StWb;
          ClsLoad, ClsStore: state_d = StMem;
          ClsBranch: begin
            pc_we  = 1'b1;
            pc_sel = branch_taken;
            retire = 1'b1;
          end
          default:           state_d = StHalt;
        endcase
      end
      StMem: begin
        if (mem_ready) begin
          if (cls_q == ClsStore) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
    if (retire) begin
      state_d = halt_req ? StHalt : StFetch;
    end
  end

  assign count_d = retire ? count_q + 32'd1 : count_q;

  // Moore outputs decoded from the state and the class latched in DECODE.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = AluAdd;
    reg_we       = 1'b0;
    wb_sel       = 1'b0;
    case (state_q)
      StFetch: mem_req = 1'b1;
      StExec: begin
        unique case (cls_q)
          ClsR:              alu_op = AluFunct;
          ClsLoad, ClsStore: alu_src_b = 1'b1;
          ClsBranch:         alu_op = AluSub;
          default:           alu_op = AluAdd;
        endcase
      end
      StMem: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == ClsStore);
      end
      StWb: begin
        reg_we = 1'b1;
        wb_sel = (cls_q == ClsLoad);
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: table of single instructions with hand-computed
// latency/strobe expectations, plus halt, illegal-opcode and mid-fetch reset sequences.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        branch_taken;
  logic        halt_req;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic        pc_sel;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_we;
  logic        wb_sel;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] instr_count;

  multicycle_control dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .halt_req     (halt_req),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .state        (state),
    .illegal      (illegal),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] op;
    int         fw;     // FETCH wait cycles
    int         mw;     // MEM wait cycles
    logic       bt;
    logic       hr;
    logic       noise;  // drive mem_ready=1 whenever mem_req=0
    int         lat;
    logic [2:0] fin;
    logic       rw;
    logic       mwe;
    logic       wbs;
    logic       pcs;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_count = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one instruction starting at a negedge in FETCH; returns at the negedge after retire.
  task automatic run_instr(input vec_t v, output int lat, output logic [2:0] fin,
                           output logic rw, output logic mwe, output logic wbs,
                           output logic pcs);
    int waitcnt;
    logic [2:0] prev;
    bit done;
    lat = 0; rw = 0; mwe = 0; wbs = 0; pcs = 0;
    waitcnt = 0; prev = 3'd7; done = 0;
    opcode = v.op; branch_taken = v.bt; halt_req = v.hr;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (state !== prev) waitcnt = 0;
      prev = state;
      if (mem_req) begin
        mem_ready = (waitcnt == ((state == 3'd0) ? v.fw : v.mw));
        waitcnt++;
      end else begin
        mem_ready = v.noise;
      end
      #1;
      if (mem_we) mwe = 1'b1;
      if (reg_we) begin
        rw  = 1'b1;
        wbs = wb_sel;
      end
      if (pc_we) begin
        done = 1;
        lat  = c;
        pcs  = pc_sel;
      end
      @(negedge clk);
      mem_ready = 1'b0;
    end
    fin = state;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[7];
  int   lat;
  logic [2:0] fin;
  logic rw, mwe, wbs, pcs;
  int   bad;

  initial begin
    vecs[0] = '{7'b0000000, 0, 0, 1'b0, 1'b0, 1'b0, 4,  3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{7'b0100011, 3, 2, 1'b0, 1'b0, 1'b0, 10, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{7'b0101011, 0, 0, 1'b0, 1'b0, 1'b0, 4,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{7'b0000100, 0, 0, 1'b1, 1'b0, 1'b0, 3,  3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{7'b0000100, 1, 0, 1'b0, 1'b0, 1'b1, 4,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{7'b0000000, 2, 0, 1'b0, 1'b0, 1'b1, 6,  3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{7'b0101011, 0, 3, 1'b0, 1'b1, 1'b0, 7,  3'd5, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; opcode = 7'd0; mem_ready = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
    #1;
    check("reset_state", {29'd0, state}, 32'd0);
    check("reset_count", instr_count, 32'd0);
    check("reset_illegal", {31'd0, illegal}, 32'd0);
    check("reset_strobes",
          {23'd0, mem_req, mem_addr_sel, mem_we, ir_we, pc_we, pc_sel, alu_src_b, alu_op, reg_we,
           wb_sel}, 32'h400);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("first_mem_req", {31'd0, mem_req}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      run_instr(vecs[i], lat, fin, rw, mwe, wbs, pcs);
      exp_count++;
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_final_state", i), {29'd0, fin}, {29'd0, vecs[i].fin});
      check($sformatf("v%0d_reg_we", i), {31'd0, rw}, {31'd0, vecs[i].rw});
      check($sformatf("v%0d_mem_we", i), {31'd0, mwe}, {31'd0, vecs[i].mwe});
      check($sformatf("v%0d_wb_sel", i), {31'd0, wbs}, {31'd0, vecs[i].wbs});
      check($sformatf("v%0d_pc_sel", i), {31'd0, pcs}, {31'd0, vecs[i].pcs});
      check($sformatf("v%0d_count", i), instr_count, exp_count);
    end

    // Halted after the store: no further memory activity even with mem_ready toggling.
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      mem_ready = c[0];
      #1;
      if (mem_req || state != 3'd5) bad++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    check("halt_no_mem_req", bad, 0);

    // Illegal opcode: HALT after DECODE, sticky flag, quiet strobes, cleared by reset.
    do_reset();
    halt_req = 1'b0;
    exp_count = 32'd0;
    opcode = 7'b1111111;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("illegal_decode_state", {29'd0, state}, 32'd1);
    @(negedge clk);
    #1;
    check("illegal_halt_state", {29'd0, state}, 32'd5);
    check("illegal_flag", {31'd0, illegal}, 32'd1);
    check("illegal_count", instr_count, exp_count);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      mem_ready = c[0]; branch_taken = c[1]; halt_req = c[2];
      #1;
      if ({mem_req, mem_addr_sel, mem_we, ir_we, pc_we, pc_sel, alu_src_b, alu_op, reg_we,
           wb_sel} != 11'd0 || state != 3'd5 || !illegal) bad++;
      @(negedge clk);
    end
    mem_ready = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
    check("illegal_quiet_20", bad, 0);
    #2 rst = 1'b1;
    #1;
    check("illegal_cleared", {31'd0, illegal}, 32'd0);
    check("illegal_rst_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-FETCH after one retire, then a late mem_ready completes a fresh fetch.
    run_instr(vecs[0], lat, fin, rw, mwe, wbs, pcs);
    check("pre_reset_count", instr_count, 32'd1);
    opcode = 7'b0000000;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midfetch_state", {29'd0, state}, 32'd0);
    check("midfetch_count", instr_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_mem_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("late_ready_ir_we", {31'd0, ir_we}, 32'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("late_ready_decode", {29'd0, state}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("late_fetch_wb", {30'd0, reg_we, pc_we}, 32'd3);
    @(negedge clk);
    #1;
    check("late_fetch_count", instr_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
